// File: rtl/rx_bitalign_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rx_bitalign_pkg
// Purpose : Shared state encoding and default widths for the Rx bit-align
//           lane sequencer and its lock filter.
// Rev     : 1.0  initial release
// ============================================================================
package rx_bitalign_pkg;

    typedef enum logic [2:0] {
        S_LOCK_WAIT = 3'd0,
        S_RSTRT     = 3'd1,
        S_GUARD     = 3'd2,
        S_WAIT      = 3'd3,
        S_NEXT      = 3'd4,
        S_DONE      = 3'd5,
        S_FAIL      = 3'd6
    } seq_state_t;

    localparam int DEF_LOCK_STABLE_W = 10;
    localparam int DEF_TIMEOUT_W     = 20;
    localparam int DEF_MAX_RETRY     = 3;

endpackage
`default_nettype wire

// File: rtl/rx_bitalign_lock_filter.sv
`default_nettype none
// ============================================================================
// Module  : rx_bitalign_lock_filter
// Purpose : Declares the PLL lock stable once it has been high for
//           2^LOCK_STABLE_W consecutive cycles; any low cycle restarts it.
// Rev     : 1.0  initial release
// ============================================================================
module rx_bitalign_lock_filter
    import rx_bitalign_pkg::*;
#(
    parameter int LOCK_STABLE_W = DEF_LOCK_STABLE_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pll_lock_i,
    output logic lock_stable_o
);

    logic [LOCK_STABLE_W-1:0] cnt_q;
    logic [LOCK_STABLE_W-1:0] cnt_d;

    // Saturates so lock_stable stays high for as long as lock is held.
    always_comb begin
        cnt_d = cnt_q;
        if (!pll_lock_i) begin
            cnt_d = '0;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + LOCK_STABLE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lock_stable_o = pll_lock_i & (&cnt_q);

endmodule
`default_nettype wire

// File: rtl/rx_bitalign_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rx_bitalign_lane_sequencer
// Purpose : Trains the per-lane Rx bit-align engines one lane at a time after
//           PLL lock, with guard, timeout and retry; reports lane status.
//           Optional RX_BITALIGN_PERIODIC_RETRAIN_EN adds periodic retraining.
// Rev     : 1.0  initial release
// ============================================================================
module rx_bitalign_lane_sequencer
    import rx_bitalign_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int LOCK_STABLE_W = DEF_LOCK_STABLE_W,
    parameter int RSTRT_CYC     = 4,
    parameter int GUARD_CYC     = 8,
    parameter int TIMEOUT_W     = DEF_TIMEOUT_W,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
`ifdef RX_BITALIGN_PERIODIC_RETRAIN_EN
    ,
    parameter int RETRAIN_W     = 24
`endif
) (
    input  logic                 SCLK,
    input  logic                 RESETN,
    input  logic                 PLL_LOCK,
    input  logic                 SEQ_START,
    input  logic [NUM_LANES-1:0] LANE_DONE,
    input  logic [NUM_LANES-1:0] LANE_ERR,
    output logic [NUM_LANES-1:0] LANE_RSTRT,
    output logic [NUM_LANES-1:0] LANE_HOLD,
    output logic [2:0]           CUR_LANE,
    output logic [NUM_LANES-1:0] LANE_OK,
    output logic [NUM_LANES-1:0] LANE_FAIL,
    output logic                 ALIGN_DONE,
    output logic                 ALIGN_ERR,
    output logic                 BUSY
);

    localparam int PH_MAX  = (RSTRT_CYC > GUARD_CYC) ? RSTRT_CYC : GUARD_CYC;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [PH_W-1:0]    RSTRT_LAST = PH_W'(RSTRT_CYC - 1);
    localparam logic [PH_W-1:0]    GUARD_LAST = PH_W'(GUARD_CYC - 1);
    localparam logic [2:0]         LAST_LANE  = 3'(NUM_LANES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    seq_state_t             state_q, state_d;
    logic [2:0]             lane_q, lane_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [PH_W-1:0]        ph_q, ph_d;
    logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
    logic [NUM_LANES-1:0]   ok_q, ok_d;
    logic [NUM_LANES-1:0]   fail_q, fail_d;
    logic [NUM_LANES-1:0]   rstrt_q, hold_q;
    logic [2:0]             cur_q;
    logic                   adone_q, aerr_q, busy_q;

    logic                   lock_stable;
    logic                   auto_start;
    logic                   start_req;
    logic                   lane_act;
    logic [NUM_LANES-1:0]   lane_sel, lane_sel_d;

    rx_bitalign_lock_filter #(
        .LOCK_STABLE_W (LOCK_STABLE_W)
    ) u_lock_filter (
        .clk_i         (SCLK),
        .rst_ni        (RESETN),
        .pll_lock_i    (PLL_LOCK),
        .lock_stable_o (lock_stable)
    );

`ifdef RX_BITALIGN_PERIODIC_RETRAIN_EN
    logic [RETRAIN_W-1:0] retrain_q;

    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            retrain_q <= '0;
        end else if (state_q == S_DONE && state_d == S_DONE) begin
            retrain_q <= retrain_q + RETRAIN_W'(1);
        end else begin
            retrain_q <= '0;
        end
    end

    assign auto_start = (state_q == S_DONE) && (&retrain_q);
`else
    assign auto_start = 1'b0;
`endif

    assign start_req  = SEQ_START | auto_start;
    assign lane_sel   = NUM_LANES'(1) << lane_q;
    assign lane_sel_d = NUM_LANES'(1) << lane_d;
    assign lane_act   = (state_d == S_RSTRT) || (state_d == S_GUARD) || (state_d == S_WAIT);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        retry_d = retry_q;
        ph_d    = ph_q;
        tmo_d   = tmo_q;
        ok_d    = ok_q;
        fail_d  = fail_q;

        // Lock loss beats restart requests, which beat normal sequencing.
        if (state_q != S_LOCK_WAIT && !PLL_LOCK) begin
            state_d = S_LOCK_WAIT;
        end else if (start_req && (state_q == S_DONE || state_q == S_FAIL)) begin
            state_d = S_RSTRT;
            lane_d  = '0;
            retry_d = '0;
            ph_d    = '0;
            ok_d    = '0;
            fail_d  = '0;
        end else begin
            case (state_q)
                S_LOCK_WAIT: begin
                    if (lock_stable) begin
                        state_d = S_RSTRT;
                        lane_d  = '0;
                        retry_d = '0;
                        ph_d    = '0;
                        ok_d    = '0;
                        fail_d  = '0;
                    end
                end
                S_RSTRT: begin
                    if (ph_q == RSTRT_LAST) begin
                        state_d = S_GUARD;
                        ph_d    = '0;
                        tmo_d   = '0;
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                S_GUARD: begin
                    tmo_d = tmo_q + TIMEOUT_W'(1);
                    if (ph_q == GUARD_LAST) begin
                        state_d = S_WAIT;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                S_WAIT: begin
                    tmo_d = tmo_q + TIMEOUT_W'(1);
                    if (|(LANE_DONE & lane_sel)) begin
                        ok_d    = ok_q | lane_sel;
                        state_d = S_NEXT;
                    end else if ((|(LANE_ERR & lane_sel)) || (&tmo_q)) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RETRY_W'(1);
                            ph_d    = '0;
                            state_d = S_RSTRT;
                        end else begin
                            fail_d  = fail_q | lane_sel;
                            state_d = S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (lane_q == LAST_LANE) begin
                        state_d = (fail_q == '0) ? S_DONE : S_FAIL;
                    end else begin
                        lane_d  = lane_q + 3'd1;
                        retry_d = '0;
                        ph_d    = '0;
                        state_d = S_RSTRT;
                    end
                end
                S_DONE, S_FAIL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_LOCK_WAIT;
                end
            endcase
        end
    end

    // Outputs are registered from next-state so they line up with state_q.
    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_LOCK_WAIT;
            lane_q  <= '0;
            retry_q <= '0;
            ph_q    <= '0;
            tmo_q   <= '0;
            ok_q    <= '0;
            fail_q  <= '0;
            rstrt_q <= '0;
            hold_q  <= '1;
            cur_q   <= '0;
            adone_q <= 1'b0;
            aerr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            retry_q <= retry_d;
            ph_q    <= ph_d;
            tmo_q   <= tmo_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
            rstrt_q <= (state_d == S_RSTRT) ? lane_sel_d : '0;
            hold_q  <= lane_act ? ~lane_sel_d : '1;
            cur_q   <= lane_d;
            adone_q <= (state_d == S_DONE);
            aerr_q  <= (state_d == S_FAIL);
            busy_q  <= !((state_d == S_DONE) || (state_d == S_FAIL));
        end
    end

    assign LANE_RSTRT = rstrt_q;
    assign LANE_HOLD  = hold_q;
    assign CUR_LANE   = cur_q;
    assign LANE_OK    = ok_q;
    assign LANE_FAIL  = fail_q;
    assign ALIGN_DONE = adone_q;
    assign ALIGN_ERR  = aerr_q;
    assign BUSY       = busy_q;

endmodule
`default_nettype wire

// File: doc/rx_bitalign_lane_sequencer.md
Name: rx_bitalign_lane_sequencer

Overview:
- Multi-lane controller that sequences the per-lane Rx IOD bit-alignment training engines, one lane at a time, after PLL lock.
- Issues restart pulses and holds idle lanes; watches DONE/ERR with a timeout and retries failed lanes.
- Reports aggregate and per-lane status to the receiver top level.
- Sits between the clock/reset block and the per-lane bit-align instances.

Parameters:
- NUM_LANES, 4, number of lanes sequenced (1..8).
- LOCK_STABLE_W, 10, PLL_LOCK must be high continuously for 2^LOCK_STABLE_W SCLK cycles before training.
- RSTRT_CYC, 4, width in cycles of each restart pulse (>=1).
- GUARD_CYC, 8, cycles after restart deassertion during which lane DONE/ERR are ignored.
- TIMEOUT_W, 20, per-attempt timeout of 2^TIMEOUT_W cycles.
- MAX_RETRY, 3, retries per lane after the first attempt.

Ports:
- SCLK  in  1  sole clock.
- RESETN  in  1  asynchronous active-low reset.
- PLL_LOCK  in  1  fabric PLL lock, already synchronous to SCLK.
- SEQ_START  in  1  one-cycle pulse that requests full retraining; ignored unless in DONE or FAIL state.
- LANE_DONE  in  NUM_LANES  per-lane BIT_ALGN_DONE (level).
- LANE_ERR  in  NUM_LANES  per-lane BIT_ALGN_ERR (level).
- LANE_RSTRT  out  NUM_LANES  per-lane BIT_ALGN_RSTRT.
- LANE_HOLD  out  NUM_LANES  per-lane BIT_ALGN_HOLD.
- CUR_LANE  out  3  index of the lane being trained.
- LANE_OK  out  NUM_LANES  sticky per-lane aligned flag.
- LANE_FAIL  out  NUM_LANES  sticky per-lane failed-after-retries flag.
- ALIGN_DONE  out  1  all lanes processed with no lane failed.
- ALIGN_ERR  out  1  all lanes processed with at least one lane failed.
- BUSY  out  1  high in every state except DONE and FAIL.

Behaviour:
- Reset values:
  - All outputs 0, except LANE_HOLD which resets to all-ones.
  - State LOCK_WAIT; counters 0.
- States: LOCK_WAIT, RSTRT, GUARD, WAIT, NEXT, DONE, FAIL.
- LOCK_WAIT:
  - Stability counter increments while PLL_LOCK=1 and clears on 0.
  - At terminal count, lane=0, retry=0, LANE_OK and LANE_FAIL cleared, go to RSTRT.
- RSTRT: LANE_RSTRT[lane]=1 for exactly RSTRT_CYC cycles, then go to GUARD.
- GUARD: GUARD_CYC cycles with DONE/ERR ignored; the timeout counter starts at GUARD entry.
- WAIT:
  - LANE_DONE[lane]=1 -> set LANE_OK[lane], go to NEXT.
  - Else LANE_ERR[lane]=1 or timeout reached -> if retry<MAX_RETRY, increment retry and go to RSTRT; else set LANE_FAIL[lane] and go to NEXT.
  - DONE and ERR high in the same cycle counts as success.
- NEXT:
  - If lane==NUM_LANES-1, go to DONE when LANE_FAIL==0, else FAIL.
  - Otherwise increment lane, set retry=0, go to RSTRT.
  - Costs one cycle.
- LANE_HOLD:
  - Bit=0 only for the current lane while in RSTRT, GUARD or WAIT.
  - All other lanes, and all lanes in LOCK_WAIT, DONE or FAIL, are 1 (aligned lanes keep their tap delay).
- ALIGN_DONE/ALIGN_ERR:
  - Registered, valid in DONE/FAIL respectively, mutually exclusive.
  - Cleared on leaving DONE/FAIL.
- SEQ_START in DONE or FAIL:
  - Go to RSTRT at lane 0 and clear LANE_OK/LANE_FAIL.
  - Skips LOCK_WAIT, since lock is still held.
- PLL_LOCK=0 in any state other than LOCK_WAIT:
  - Next cycle: go to LOCK_WAIT.
  - Deassert all LANE_RSTRT, set all LANE_HOLD, clear ALIGN_DONE and ALIGN_ERR.
  - LANE_OK/LANE_FAIL clear at LOCK_WAIT completion.
- Priority: lock loss > SEQ_START > normal transitions.
- CUR_LANE is zero-extended to 3 bits.
- The retry counter saturates at MAX_RETRY; the timeout counter is TIMEOUT_W bits, compared at all-ones.

Optional Feature:
- Macro: RX_BITALIGN_PERIODIC_RETRAIN_EN.
- Defined:
  - Adds parameter RETRAIN_W (default 24).
  - A free-running counter in DONE state triggers an internal SEQ_START after 2^RETRAIN_W cycles.
  - The counter clears on leaving DONE.
  - FAIL state is not retrained automatically.
- Undefined: no counter; retraining happens only via SEQ_START or lock loss.

Decomposition:
- Shared package rx_bitalign_pkg holds:
  - State enum type (seq_state_t) with 3-bit encoding.
  - Default constants for LOCK_STABLE_W, TIMEOUT_W and MAX_RETRY.
- One sub-module, rx_bitalign_lock_filter: the PLL_LOCK stability counter producing lock_stable.
- The FSM, counters and lane mux stay in the top module.

Test Plan:
- Config NUM_LANES=4, LOCK_STABLE_W=4, TIMEOUT_W=6, MAX_RETRY=1:
  - Lock high for 16 cycles; each lane raises DONE 10 cycles after GUARD.
  - Expect RSTRT pulses in order on lanes 0..3, each 4 cycles wide.
  - Expect ALIGN_DONE=1, LANE_OK=4'hF, BUSY=0.
- Lane 2 ERR on the first attempt, DONE on the retry:
  - Expect two RSTRT pulses on lane 2.
  - Expect LANE_OK=4'hF, ALIGN_DONE=1.
- Lane 1 never responds:
  - Expect two timeouts of 64 cycles each.
  - Expect LANE_FAIL=4'b0010, LANE_OK=4'b1101, ALIGN_ERR=1, ALIGN_DONE=0.
- PLL_LOCK dropped during WAIT on lane 2:
  - Expect LANE_HOLD=4'hF and LANE_RSTRT=0 the next cycle.
  - After re-lock plus 16 cycles, training restarts at lane 0 with LANE_OK cleared.
- DONE already high and stale during GUARD: ignored; success only on DONE observed in WAIT.
- SEQ_START in DONE state: restarts at lane 0 without LOCK_WAIT. A SEQ_START pulse while BUSY has no effect.
